// File: rtl/id_stage_if.sv
// ID-stage bus: decode inputs, writeback port, hazard-unit taps and the registered ID/EX payload.
interface id_stage_if;
  logic [31:0] instrD;
  logic        validD;
  logic [31:0] PCD;
  logic [31:0] PcpD;
  logic        FlushE;

  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;

  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;

  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [31:0] PCE;
  logic [31:0] PcpE;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [3:0]  ALUControlE;
  logic [1:0]  ResultSrcE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        BranchE;
  logic        JumpE;
  logic        ALUSrcE;
  logic        validE;
  logic        illegalE;

  modport master (
    output instrD, validD, PCD, PcpD, FlushE, RegWriteW, RdW, ResultW,
    input  Rs1D, Rs2D,
    input  RD1E, RD2E, ImmExtE, PCE, PcpE, Rs1E, Rs2E, RdE, ALUControlE, ResultSrcE,
    input  RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, validE, illegalE
  );

  modport slave (
    input  instrD, validD, PCD, PcpD, FlushE, RegWriteW, RdW, ResultW,
    output Rs1D, Rs2D,
    output RD1E, RD2E, ImmExtE, PCE, PcpE, Rs1E, Rs2E, RdE, ALUControlE, ResultSrcE,
    output RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, validE, illegalE
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: 32x32 register file, control decode, immediate extension and ID/EX register.
// Define RF_BYPASS_EN to forward a same-cycle writeback onto the register-file read ports.
module id_stage (
  input logic       clk,
  input logic       rst_n,
  id_stage_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  logic [XLEN-1:0] rf [NREG];
  logic [XLEN-1:0] instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            alt;
  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  logic [XLEN-1:0] imm;
  logic [3:0]      alu_ctl;
  logic [1:0]      res_src;
  logic            reg_write;
  logic            mem_write;
  logic            branch;
  logic            jump;
  logic            alu_src;
  logic            illegal;
  logic            bubble;

  assign instr  = bus.instrD;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign alt    = instr[30];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign bus.Rs1D = rs1;
  assign bus.Rs2D = rs2;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic sel_alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = sel_alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = sel_alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Register file: x0 is never written, reset clears every entry and wins over writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (bus.RegWriteW && (bus.RdW != '0)) begin
      rf[bus.RdW] <= bus.ResultW;
    end
  end

  always_comb begin
    rd1 = (rs1 == '0) ? '0 : rf[rs1];
    rd2 = (rs2 == '0) ? '0 : rf[rs2];
`ifdef RF_BYPASS_EN
    if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == rs1)) rd1 = bus.ResultW;
    if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == rs2)) rd2 = bus.ResultW;
`endif
  end

  // Control decode and immediate selection; unknown opcodes keep every control low.
  always_comb begin
    imm       = '0;
    alu_ctl   = ALU_ADD;
    res_src   = 2'b00;
    reg_write = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    alu_src   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        alu_ctl   = alu_op(funct3, alt);
      end
      OP_I: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        imm       = {{20{instr[31]}}, instr[31:20]};
        alu_ctl   = alu_op(funct3, (funct3 == 3'b101) && alt);
      end
      OP_LOAD: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        res_src   = 2'b01;
        imm       = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BR: begin
        branch  = 1'b1;
        alu_ctl = ALU_SUB;
        imm     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_JAL: begin
        reg_write = 1'b1;
        jump      = 1'b1;
        res_src   = 2'b10;
        imm       = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR: begin
        reg_write = 1'b1;
        jump      = 1'b1;
        alu_src   = 1'b1;
        res_src   = 2'b10;
        imm       = {{20{instr[31]}}, instr[31:20]};
      end
      OP_LUI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_ctl   = ALU_PASSB;
        imm       = {instr[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  assign bubble = bus.FlushE || !bus.validD;

  // ID/EX register: data always follows ID, controls collapse to a bubble on flush or invalid input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.RD1E        <= '0;
      bus.RD2E        <= '0;
      bus.ImmExtE     <= '0;
      bus.PCE         <= '0;
      bus.PcpE        <= '0;
      bus.Rs1E        <= '0;
      bus.Rs2E        <= '0;
      bus.RdE         <= '0;
      bus.ALUControlE <= '0;
      bus.ResultSrcE  <= '0;
      bus.RegWriteE   <= 1'b0;
      bus.MemWriteE   <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.ALUSrcE     <= 1'b0;
      bus.validE      <= 1'b0;
      bus.illegalE    <= 1'b0;
    end else begin
      bus.RD1E    <= rd1;
      bus.RD2E    <= rd2;
      bus.ImmExtE <= imm;
      bus.PCE     <= bus.PCD;
      bus.PcpE    <= bus.PcpD;
      bus.Rs1E    <= rs1;
      bus.Rs2E    <= rs2;
      bus.RdE     <= instr[11:7];
      if (bubble) begin
        bus.ALUControlE <= '0;
        bus.ResultSrcE  <= '0;
        bus.RegWriteE   <= 1'b0;
        bus.MemWriteE   <= 1'b0;
        bus.BranchE     <= 1'b0;
        bus.JumpE       <= 1'b0;
        bus.ALUSrcE     <= 1'b0;
        bus.validE      <= 1'b0;
        bus.illegalE    <= 1'b0;
      end else begin
        bus.ALUControlE <= alu_ctl;
        bus.ResultSrcE  <= res_src;
        bus.RegWriteE   <= reg_write;
        bus.MemWriteE   <= mem_write;
        bus.BranchE     <= branch;
        bus.JumpE       <= jump;
        bus.ALUSrcE     <= alu_src;
        bus.validE      <= 1'b1;
        bus.illegalE    <= illegal;
      end
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage; expected RD2E on the same-cycle write case depends on RF_BYPASS_EN.
module tb_id_stage;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  id_stage_if bus ();

  id_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Order: RegWrite MemWrite Branch Jump ALUSrc ResultSrc[1:0] ALUControl[3:0] valid illegal
  task automatic chk_cw(input string tag, input logic [12:0] exp);
    chk(tag, 32'({bus.RegWriteE, bus.MemWriteE, bus.BranchE, bus.JumpE, bus.ALUSrcE,
                  bus.ResultSrcE, bus.ALUControlE, bus.validE, bus.illegalE}), 32'(exp));
  endtask

  // Order: RegWrite MemWrite Branch Jump valid illegal
  task automatic chk_must(input string tag, input logic [5:0] exp);
    chk(tag, 32'({bus.RegWriteE, bus.MemWriteE, bus.BranchE, bus.JumpE,
                  bus.validE, bus.illegalE}), 32'(exp));
  endtask

  initial begin
    logic [31:0] exp_rd2_byp;
`ifdef RF_BYPASS_EN
    exp_rd2_byp = 32'hDEADBEEF;
`else
    exp_rd2_byp = 32'h0;
`endif
    total = 0;
    bad   = 0;
    clk   = 1'b0;

    // Reset with a simultaneous writeback to x3 that must be discarded
    rst_n         = 1'b0;
    bus.instrD    = 32'h00500093;
    bus.validD    = 1'b1;
    bus.PCD       = 32'h0;
    bus.PcpD      = 32'h0;
    bus.FlushE    = 1'b0;
    bus.RegWriteW = 1'b1;
    bus.RdW       = 5'd3;
    bus.ResultW   = 32'h0000AAAA;
    tick();
    chk_cw("rst_ctrl", 13'b0_0_0_0_0_00_0000_0_0);
    chk("rst_rd1", bus.RD1E, 32'h0);
    chk("rst_imm", bus.ImmExtE, 32'h0);
    chk("rst_rde", 32'(bus.RdE), 32'h0);

    // ADDI x1,x0,5
    rst_n         = 1'b1;
    bus.RegWriteW = 1'b0;
    bus.PCD       = 32'h100;
    bus.PcpD      = 32'h104;
    #1;
    chk("addi_rs1d", 32'(bus.Rs1D), 32'h0);
    chk("addi_rs2d", 32'(bus.Rs2D), 32'h5);
    tick();
    chk_cw("addi_ctrl", 13'b1_0_0_0_1_00_0000_1_0);
    chk("addi_rde", 32'(bus.RdE), 32'h1);
    chk("addi_imm", bus.ImmExtE, 32'h5);
    chk("addi_rd1", bus.RD1E, 32'h0);
    chk("addi_pce", bus.PCE, 32'h100);
    chk("addi_pcpe", bus.PcpE, 32'h104);

    // Read x3 (reset-discarded write) while writing x1=5
    bus.instrD    = 32'h00018093;
    bus.RegWriteW = 1'b1;
    bus.RdW       = 5'd1;
    bus.ResultW   = 32'h5;
    tick();
    chk("x3_cleared", bus.RD1E, 32'h0);

    // SUB x2,x1,x2 while writing x2
    bus.instrD  = 32'h40208133;
    bus.RdW     = 5'd2;
    bus.ResultW = 32'hDEADBEEF;
    #1;
    chk("sub_rs1d", 32'(bus.Rs1D), 32'h1);
    chk("sub_rs2d", 32'(bus.Rs2D), 32'h2);
    tick();
    chk_cw("sub_ctrl", 13'b1_0_0_0_0_00_0001_1_0);
    chk("sub_rd1", bus.RD1E, 32'h5);
    chk("sub_rd2_same", bus.RD2E, exp_rd2_byp);
    chk("sub_rs2e", 32'(bus.Rs2E), 32'h2);
    bus.RegWriteW = 1'b0;
    tick();
    chk("sub_rd2_late", bus.RD2E, 32'hDEADBEEF);

    // BEQ x0,x0,-4
    bus.instrD = 32'hFE000EE3;
    tick();
    chk_cw("beq_ctrl", 13'b0_0_1_0_0_00_0001_1_0);
    chk("beq_imm", bus.ImmExtE, 32'hFFFFFFFC);

    // JAL flushed, with a writeback of x4 in the same cycle
    bus.instrD    = 32'h0080006F;
    bus.FlushE    = 1'b1;
    bus.RegWriteW = 1'b1;
    bus.RdW       = 5'd4;
    bus.ResultW   = 32'h55;
    tick();
    chk_must("jal_flush", 6'b0_0_0_0_0_0);
    bus.FlushE    = 1'b0;
    bus.RegWriteW = 1'b0;
    tick();
    chk_must("jal_ctrl", 6'b1_0_0_1_1_0);
    chk("jal_ressrc", 32'(bus.ResultSrcE), 32'h2);
    chk("jal_imm", bus.ImmExtE, 32'h8);

    // ADD x5,x0,x4 while writing x0 (ignored) ; x4 written during flush
    bus.instrD    = 32'h004002B3;
    bus.RegWriteW = 1'b1;
    bus.RdW       = 5'd0;
    bus.ResultW   = 32'h1234;
    tick();
    chk_cw("add_ctrl", 13'b1_0_0_0_0_00_0000_1_0);
    chk("x0_same", bus.RD1E, 32'h0);
    chk("x4_flush_wb", bus.RD2E, 32'h55);
    chk("r_imm", bus.ImmExtE, 32'h0);
    bus.RegWriteW = 1'b0;
    tick();
    chk("x0_after", bus.RD1E, 32'h0);

    // LUI x6,0x12345
    bus.instrD = 32'h12345337;
    tick();
    chk_cw("lui_ctrl", 13'b1_0_0_0_1_00_1010_1_0);
    chk("lui_imm", bus.ImmExtE, 32'h12345000);

    // SW x4,12(x0)
    bus.instrD = 32'h00402623;
    tick();
    chk_cw("sw_ctrl", 13'b0_1_0_0_1_00_0000_1_0);
    chk("sw_imm", bus.ImmExtE, 32'h0000000C);

    // LW x7,-8(x0)
    bus.instrD = 32'hFF802383;
    tick();
    chk_cw("lw_ctrl", 13'b1_0_0_0_1_01_0000_1_0);
    chk("lw_imm", bus.ImmExtE, 32'hFFFFFFF8);
    chk("lw_rde", 32'(bus.RdE), 32'h7);

    // SRAI x1,x1,3
    bus.instrD = 32'h4030D093;
    tick();
    chk_cw("srai_ctrl", 13'b1_0_0_0_1_00_1001_1_0);
    chk("srai_imm", bus.ImmExtE, 32'h00000403);

    // ADDI x1,x1,0x400 (bit30 set, still ADD)
    bus.instrD = 32'h40008093;
    tick();
    chk_cw("addi30_ctrl", 13'b1_0_0_0_1_00_0000_1_0);
    chk("addi30_imm", bus.ImmExtE, 32'h00000400);

    // JALR x1,0(x2)
    bus.instrD = 32'h000100E7;
    tick();
    chk_cw("jalr_ctrl", 13'b1_0_0_1_1_10_0000_1_0);
    chk("jalr_rd1", bus.RD1E, 32'hDEADBEEF);

    // Invalid slot becomes a bubble
    bus.validD = 1'b0;
    bus.instrD = 32'h00500093;
    tick();
    chk_cw("bubble_ctrl", 13'b0_0_0_0_0_00_0000_0_0);

    // Unknown opcode, then reset
    bus.validD = 1'b1;
    bus.instrD = 32'h0000007F;
    tick();
    chk_cw("illegal_ctrl", 13'b0_0_0_0_0_00_0000_1_1);
    rst_n = 1'b0;
    tick();
    chk_cw("illegal_rst", 13'b0_0_0_0_0_00_0000_0_0);

    // First edge after reset captures normally; x4 was cleared
    rst_n      = 1'b1;
    bus.instrD = 32'h004002B3;
    tick();
    chk_cw("post_rst_ctrl", 13'b1_0_0_0_0_00_0000_1_0);
    chk("x4_cleared", bus.RD2E, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 instrD  in  32  instruction from IF/ID register; validD  in  1  instrD holds a real instruction.
REQ-004 PCD, PcpD  in  32 each  PC and PC+4 of instrD.
REQ-005 FlushE  in  1  insert bubble into ID/EX on next edge.
REQ-006 RegWriteW  in  1, RdW  in  5, ResultW  in  32  writeback port.
REQ-007 Rs1D, Rs2D  out  5  combinational instrD[19:15], instrD[24:20] for hazard unit.
REQ-008 Registered ID/EX outputs: RD1E, RD2E, ImmExtE, PCE, PcpE (32); Rs1E, Rs2E, RdE (5); ALUControlE (4); ResultSrcE (2); RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, validE, illegalE (1).

Function
REQ-009 Register file SHALL be 32x32; x0 reads 0 always; write on rising edge when RegWriteW=1 and RdW!=0.
REQ-010 Reads SHALL be combinational from Rs1D/Rs2D; result captured into RD1E/RD2E on the edge (latency 1 cycle ID->EX).
REQ-011 Decode SHALL support RV32I opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI.
REQ-012 Immediates SHALL be sign-extended per type: I instr[31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}; U {[31:12],12'b0}; R gives 0.
REQ-013 ALUControl encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASSB (LUI).
REQ-014 SUB/SRA selected by instr[30] for R-type; for I-ALU only SRAI uses instr[30] (ADDI with bit30=1 stays ADD).
REQ-015 Loads/stores/JALR use ADD; branches use SUB; ALUSrcE=1 for I, load, store, JALR, LUI.
REQ-016 ResultSrcE: 00 ALU, 01 memory (load), 10 PC+4 (JAL/JALR).
REQ-017 RegWriteE=1 for R, I-ALU, load, JAL, JALR, LUI; MemWriteE only store; BranchE only branch; JumpE for JAL and JALR.
REQ-018 Unknown opcode with validD=1: all control outputs 0, illegalE=1, validE=1.
REQ-019 validD=0: ID/EX captures a bubble (all control, validE, illegalE = 0).
REQ-020 FlushE=1: ID/EX SHALL capture a bubble regardless of validD; data fields may take any value but RegWriteE, MemWriteE, BranchE, JumpE, validE, illegalE SHALL be 0.
REQ-021 Priority: rst_n low > FlushE > normal capture; writeback to register file still occurs when FlushE=1.
REQ-022 Writes to RdW=0 SHALL be ignored in all modes, including bypass.

Reset
REQ-023 On a rising edge with rst_n=0 all ID/EX outputs SHALL become 0 and all 32 registers SHALL clear to 0.
REQ-024 Writeback asserted in the same cycle as reset SHALL be discarded; reset dominates.
REQ-025 First edge after rst_n rises SHALL perform normal capture.

Configuration
REQ-026 Macro RF_BYPASS_EN defined: when RegWriteW=1, RdW!=0 and RdW equals Rs1D/Rs2D, the corresponding read SHALL return ResultW in the same cycle.
REQ-027 RF_BYPASS_EN undefined: read returns pre-write contents; a write becomes visible one cycle later, and the hazard unit must stall accordingly.

Verification
REQ-028 Reset then instrD=0x00500093 (ADDI x1,x0,5), validD=1 -> next edge: RdE=1, ImmExtE=5, ALUControlE=0000, ALUSrcE=1, RegWriteE=1, RD1E=0.
REQ-029 Write x2=0xDEADBEEF via RegWriteW; same cycle instrD=0x40208133 (SUB x2,x1,x2) -> RD2E=0xDEADBEEF with RF_BYPASS_EN, old x2 (0) without; ALUControlE=0001.
REQ-030 instrD=0xFE000EE3 (BEQ x0,x0,-4) -> ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=0001, RegWriteE=0.
REQ-031 instrD=0x0080006F (JAL x0,8), FlushE=1 same cycle -> JumpE=0, validE=0; repeat with FlushE=0 -> JumpE=1, ImmExtE=8, ResultSrcE=10.
REQ-032 RegWriteW=1, RdW=0, ResultW=0x1234; then read x0 -> RD1E=0 in both configurations.
REQ-033 instrD=0x0000007F, validD=1 -> illegalE=1, validE=1, all other controls 0; rst_n=0 next cycle -> illegalE=0, validE=0.
